softmax_row_sched: RTL and testbench

Round-robin scheduler that shares a single row-softmax engine among NREQ requesters, typically one per attention head. Each requester asks for one score row (row index 0..L-1) to be normalised. The scheduler grants one request at a time, launches the engine with a start pulse, and waits for the engine's done or a watchdog timeout. It then returns a response tagged with source, row and error status. It sits between the per-head attention score producers and the shared softmax datapath.

---
 rtl/softmax_row_sched.sv | 152 +++++++++++++++
 tb/tb_softmax_row_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/softmax_row_sched.sv
`default_nettype none
// ============================================================================
//  Module   : softmax_row_sched
//  Purpose  : Round-robin scheduler sharing one row-softmax engine among NREQ
//             requesters, with a watchdog on each engine launch.
//  Revision : 1.0 - initial release
// ============================================================================
module softmax_row_sched #(
  parameter int NREQ    = 4,
  parameter int L       = 8,
  parameter int TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ*$clog2(L)-1:0]      req_row,
  output logic [NREQ-1:0]                req_ready,
  output logic                           eng_start,
  output logic [$clog2(L)-1:0]           eng_row,
  output logic [$clog2(NREQ)-1:0]        eng_src,
  input  logic                           eng_done,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [$clog2(NREQ)-1:0]        rsp_src,
  output logic [$clog2(L)-1:0]           rsp_row,
  output logic                           rsp_err,
  output logic                           busy
);

  localparam int RW = $clog2(L);
  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_BUSY   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [SW-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [SW-1:0] r_src, w_src_next;
  logic [RW-1:0] r_row, w_row_next;
  logic          r_err, w_err_next;
  logic [CW-1:0] r_wdog, w_wdog_next;

  logic [2*NREQ-1:0] w_dbl;
  logic              w_any;
  logic [SW-1:0]     w_off;
  logic [SW:0]       w_sum;
  logic [SW-1:0]     w_gnt_idx;
  logic [RW-1:0]     w_gnt_row;
  logic              w_hs;

  // Rotate the request vector so the scan starts at rr_ptr; the lowest set
  // bit of the rotated view is the winner's offset from the pointer.
  always_comb begin
    w_dbl     = {req_valid, req_valid} >> r_rr_ptr;
    w_any     = 1'b0;
    w_off     = '0;
    w_gnt_row = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        w_any = 1'b1;
        w_off = SW'(j);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (SW+1)'(NREQ)) begin
      w_sum = w_sum - (SW+1)'(NREQ);
    end
    w_gnt_idx = w_sum[SW-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == SW'(i)) begin
        w_gnt_row = req_row[i*RW +: RW];
      end
    end
  end

  assign req_ready = (rst_n && (r_state == S_IDLE) && w_any) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_hs      = |(req_valid & req_ready);

  always_comb begin
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    w_src_next    = r_src;
    w_row_next    = r_row;
    w_err_next    = r_err;
    w_wdog_next   = r_wdog;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_state_next  = S_LAUNCH;
          w_src_next    = w_gnt_idx;
          w_row_next    = w_gnt_row;
          w_rr_ptr_next = (w_gnt_idx == SW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
      end
      S_LAUNCH: begin
        w_wdog_next  = '0;
        w_state_next = S_BUSY;
      end
      S_BUSY: begin
        w_wdog_next = r_wdog + 1'b1;
        // A done arriving together with the timeout still counts as success.
        if (eng_done) begin
          w_err_next   = 1'b0;
          w_state_next = S_RESP;
        end else if (r_wdog == CW'(TIMEOUT - 1)) begin
          w_err_next   = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_src    <= '0;
      r_row    <= '0;
      r_err    <= 1'b0;
      r_wdog   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_src    <= w_src_next;
      r_row    <= w_row_next;
      r_err    <= w_err_next;
      r_wdog   <= w_wdog_next;
    end
  end

  assign eng_start = (r_state == S_LAUNCH);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign eng_src   = r_src;
  assign eng_row   = r_row;
  assign rsp_src   = r_src;
  assign rsp_row   = r_row;
  assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_softmax_row_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softmax_row_sched
//  Purpose  : Directed self-checking bench for softmax_row_sched (TIMEOUT=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_softmax_row_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_row;
  logic [3:0]  req_ready;
  logic        eng_start;
  logic [2:0]  eng_row;
  logic [1:0]  eng_src;
  logic        eng_done;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_src;
  logic [2:0]  rsp_row;
  logic        rsp_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  softmax_row_sched #(.NREQ(4), .L(8), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_row   (req_row),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_row   (eng_row),
    .eng_src   (eng_src),
    .eng_done  (eng_done),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_src   (rsp_src),
    .rsp_row   (rsp_row),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Checks the grant in IDLE, then advances into the launch cycle.
  task automatic grant(input logic [3:0] oh, input int src, input int row);
    #1;
    chk("req_ready", req_ready, oh);
    step();
    chk("eng_start", eng_start, 1);
    chk("eng_src", eng_src, src);
    chk("eng_row", eng_row, row);
    chk("busy_launch", busy, 1);
    chk("req_ready_launch", req_ready, 0);
  endtask

  // From the launch cycle: done on the first BUSY cycle, then accept the response.
  task automatic finish_txn(input int src, input int row);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_src", rsp_src, src);
    chk("rsp_row", rsp_row, row);
    chk("rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_row = '0; eng_done = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_eng_row", eng_row, 0);
    chk("rst_rsp_err", rsp_err, 0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // Round robin: all four requesting, done after 3 BUSY cycles, rsp_ready high.
    req_row[2:0] = 3'd1; req_row[5:3] = 3'd2; req_row[8:6] = 3'd3; req_row[11:9] = 3'd4;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      grant(4'(1 << (n % 4)), n % 4, (n % 4) + 1);
      step(); step(); step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_src", rsp_src, n % 4);
      chk("rr_rsp_err", rsp_err, 0);
      step();
      chk("rr_idle", busy, 0);
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Single request: requester 2, row 5, done at cycle 4.
    req_row = '0;
    req_row[8:6] = 3'd5;
    req_valid = 4'b0100;
    grant(4'b0100, 2, 5);
    req_valid = '0;
    step();
    chk("single_start_pulse", eng_start, 0);
    step();
    chk("single_no_rsp_c3", rsp_valid, 0);
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_src", rsp_src, 2);
    chk("single_rsp_row", rsp_row, 5);
    chk("single_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("single_idle", busy, 0);

    // Pointer resume: grant 1, then 0 and 3 together -> 3 first, then 0.
    req_row[5:3] = 3'd3;
    req_valid = 4'b0010;
    grant(4'b0010, 1, 3);
    req_valid = '0;
    finish_txn(1, 3);
    req_row[2:0] = 3'd6; req_row[11:9] = 3'd7;
    req_valid = 4'b1001;
    grant(4'b1000, 3, 7);
    req_valid = 4'b0001;
    finish_txn(3, 7);
    grant(4'b0001, 0, 6);
    req_valid = '0;
    finish_txn(0, 6);

    // Watchdog: no done; response at cycle 6; late dones ignored.
    req_row[5:3] = 3'd4;
    req_valid = 4'b0010;
    grant(4'b0010, 1, 4);
    req_valid = '0;
    step(); step(); step(); step();
    chk("wd_no_rsp_c5", rsp_valid, 0);
    chk("wd_busy_c5", busy, 1);
    step();
    chk("wd_rsp_valid_c6", rsp_valid, 1);
    chk("wd_rsp_err", rsp_err, 1);
    chk("wd_rsp_src", rsp_src, 1);
    chk("wd_rsp_row", rsp_row, 4);
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("wd_err_hold", rsp_err, 1);
    chk("wd_valid_hold", rsp_valid, 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    eng_done = 1'b1;
    chk("wd_idle_busy", busy, 0);
    step();
    eng_done = 1'b0;
    chk("wd_late_done_busy", busy, 0);
    chk("wd_late_done_start", eng_start, 0);
    chk("wd_late_done_rsp", rsp_valid, 0);

    // Backpressure: requester 0 (pointer wraps from 2), rsp_ready low 10 cycles.
    req_row[2:0] = 3'd6;
    req_valid = 4'b0001;
    grant(4'b0001, 0, 6);
    req_valid = '0;
    step();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    req_row[5:3] = 3'd2;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_src", rsp_src, 0);
      chk("bp_rsp_row", rsp_row, 6);
      chk("bp_rsp_err", rsp_err, 0);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_busy", busy, 0);

    // Reset mid-operation: grant requester 1 (pointer -> 2), reset during BUSY.
    grant(4'b0010, 1, 2);
    step(); step();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", eng_start, 0);
    chk("mid_rst_eng_src", eng_src, 0);
    chk("mid_rst_eng_row", eng_row, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_src", rsp_src, 0);
    chk("mid_rst_rsp_row", rsp_row, 0);
    chk("mid_rst_rsp_err", rsp_err, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    req_valid = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rsp_valid", rsp_valid, 0);

    // Pointer back at 0: requester 0 before 3, then 3 served normally.
    req_row[2:0] = 3'd4; req_row[11:9] = 3'd1;
    req_valid = 4'b1001;
    grant(4'b0001, 0, 4);
    req_valid = 4'b1000;
    finish_txn(0, 4);
    grant(4'b1000, 3, 1);
    req_valid = '0;
    finish_txn(3, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
